// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage of the 16-bit pipelined CPU. Forwards operands
//                from EX/MEM and MEM/WB, runs the ALU / address generator,
//                holds the {N,Z,V} flag register, evaluates the branch
//                condition and latches the EX/MEM pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        exmem_en,
    input  logic        flush,
    input  logic [3:0]  d_opcode,
    input  logic [15:0] d_SrcData1,
    input  logic [15:0] d_SrcData2,
    input  logic [3:0]  d_SrcReg1,
    input  logic [3:0]  d_SrcReg2,
    input  logic [3:0]  d_DstReg,
    input  logic [3:0]  d_imm,
    input  logic [7:0]  d_Load_Imm,
    input  logic [3:0]  d_offset,
    input  logic [2:0]  d_condition,
    input  logic        d_Data_Mem_en,
    input  logic        d_Data_Mem_wr,
    input  logic        d_WriteReg,
    input  logic        memwb_WriteReg,
    input  logic [3:0]  memwb_DstReg,
    input  logic [15:0] memwb_Data,
    output logic [15:0] q_ALU_Out,
    output logic [15:0] q_StoreData,
    output logic [3:0]  q_DstReg,
    output logic        q_WriteReg,
    output logic        q_Data_Mem_en,
    output logic        q_Data_Mem_wr,
    output logic        q_MemToReg,
    output logic [2:0]  flags,
    output logic        br_taken
);

    localparam logic [3:0] c_OP_ADD    = 4'b0000;
    localparam logic [3:0] c_OP_SUB    = 4'b0001;
    localparam logic [3:0] c_OP_XOR    = 4'b0010;
    localparam logic [3:0] c_OP_RED    = 4'b0011;
    localparam logic [3:0] c_OP_SLL    = 4'b0100;
    localparam logic [3:0] c_OP_SRA    = 4'b0101;
    localparam logic [3:0] c_OP_ROR    = 4'b0110;
    localparam logic [3:0] c_OP_PADDSB = 4'b0111;
    localparam logic [3:0] c_OP_LW     = 4'b1000;
    localparam logic [3:0] c_OP_SW     = 4'b1001;
    localparam logic [3:0] c_OP_LLB    = 4'b1010;
    localparam logic [3:0] c_OP_LHB    = 4'b1011;
    localparam logic [3:0] c_OP_PCS    = 4'b1110;

    logic [15:0] w_a, w_b;
    logic [16:0] w_sum, w_dif;
    logic [8:0]  w_red_hi, w_red_lo;
    logic [9:0]  w_red;
    logic [15:0] w_add_sat, w_sub_sat, w_sra, w_ror, w_addr, w_paddsb;
    logic [15:0] w_alu;
    logic        w_ovf, w_set_z, w_set_nv;
    logic        w_n, w_z, w_v;

    // Forwarding mux: EX/MEM result beats MEM/WB; loads in EX/MEM are not forwarded
    always_comb begin
        w_a = d_SrcData1;
        w_b = d_SrcData2;
        if (q_WriteReg && q_DstReg != 4'd0 && q_DstReg == d_SrcReg1 && !q_MemToReg)
            w_a = q_ALU_Out;
        else if (memwb_WriteReg && memwb_DstReg != 4'd0 && memwb_DstReg == d_SrcReg1)
            w_a = memwb_Data;
        if (q_WriteReg && q_DstReg != 4'd0 && q_DstReg == d_SrcReg2 && !q_MemToReg)
            w_b = q_ALU_Out;
        else if (memwb_WriteReg && memwb_DstReg != 4'd0 && memwb_DstReg == d_SrcReg2)
            w_b = memwb_Data;
    end

    // 17-bit sign-extended sum/difference: top two bits disagree on overflow
    assign w_sum     = {w_a[15], w_a} + {w_b[15], w_b};
    assign w_dif     = {w_a[15], w_a} - {w_b[15], w_b};
    assign w_add_sat = (w_sum[16] ^ w_sum[15]) ? (w_sum[16] ? 16'h8000 : 16'h7FFF) : w_sum[15:0];
    assign w_sub_sat = (w_dif[16] ^ w_dif[15]) ? (w_dif[16] ? 16'h8000 : 16'h7FFF) : w_dif[15:0];

    // Byte-wise reduction: two 9-bit partial sums, then a 10-bit total
    assign w_red_hi = {w_a[15], w_a[15:8]} + {w_b[15], w_b[15:8]};
    assign w_red_lo = {w_a[7], w_a[7:0]} + {w_b[7], w_b[7:0]};
    assign w_red    = {w_red_hi[8], w_red_hi} + {w_red_lo[8], w_red_lo};

    assign w_sra  = $signed(w_a) >>> d_imm;
    // A 16-bit left shift by 16 yields zero, so an amount of 0 passes A
    assign w_ror  = (w_a >> d_imm) | (w_a << (5'd16 - {1'b0, d_imm}));
    assign w_addr = (w_a & 16'hFFFE) + {{11{d_offset[3]}}, d_offset, 1'b0};

    // Four independent saturating signed nibble adds
    for (genvar i = 0; i < 4; i++) begin : g_nib
        logic [4:0] w_ns;
        assign w_ns = {w_a[4*i+3], w_a[4*i +: 4]} + {w_b[4*i+3], w_b[4*i +: 4]};
        assign w_paddsb[4*i +: 4] = (w_ns[4] ^ w_ns[3]) ? (w_ns[4] ? 4'h8 : 4'h7) : w_ns[3:0];
    end

    // ALU result select and flag-update qualifiers
    always_comb begin
        w_alu    = 16'h0000;
        w_ovf    = 1'b0;
        w_set_z  = 1'b0;
        w_set_nv = 1'b0;
        case (d_opcode)
            c_OP_ADD:    begin w_alu = w_add_sat; w_ovf = w_sum[16] ^ w_sum[15]; w_set_z = 1'b1; w_set_nv = 1'b1; end
            c_OP_SUB:    begin w_alu = w_sub_sat; w_ovf = w_dif[16] ^ w_dif[15]; w_set_z = 1'b1; w_set_nv = 1'b1; end
            c_OP_XOR:    begin w_alu = w_a ^ w_b;  w_set_z = 1'b1; end
            c_OP_RED:    w_alu = {{6{w_red[9]}}, w_red};
            c_OP_SLL:    begin w_alu = w_a << d_imm; w_set_z = 1'b1; end
            c_OP_SRA:    begin w_alu = w_sra;        w_set_z = 1'b1; end
            c_OP_ROR:    begin w_alu = w_ror;        w_set_z = 1'b1; end
            c_OP_PADDSB: w_alu = w_paddsb;
            c_OP_LW,
            c_OP_SW:     w_alu = w_addr;
            c_OP_LLB:    w_alu = (w_a & 16'hFF00) | {8'h00, d_Load_Imm};
            c_OP_LHB:    w_alu = {d_Load_Imm, 8'h00} | (w_a & 16'h00FF);
            c_OP_PCS:    w_alu = w_a;
            default:     w_alu = 16'h0000;
        endcase
    end

    assign w_n = w_set_nv ? w_alu[15]         : flags[2];
    assign w_z = w_set_z  ? (w_alu == 16'h0)  : flags[1];
    assign w_v = w_set_nv ? w_ovf             : flags[0];

    // EX/MEM pipeline register and flag register; flush inserts a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            q_ALU_Out     <= 16'h0000;
            q_StoreData   <= 16'h0000;
            q_DstReg      <= 4'h0;
            q_WriteReg    <= 1'b0;
            q_Data_Mem_en <= 1'b0;
            q_Data_Mem_wr <= 1'b0;
            q_MemToReg    <= 1'b0;
            flags         <= 3'b000;
        end else if (exmem_en) begin
            q_ALU_Out     <= w_alu;
            q_StoreData   <= w_b;
            q_DstReg      <= d_DstReg;
            q_WriteReg    <= d_WriteReg    & ~flush;
            q_Data_Mem_en <= d_Data_Mem_en & ~flush;
            q_Data_Mem_wr <= d_Data_Mem_wr & ~flush;
            q_MemToReg    <= (d_opcode == c_OP_LW);
            if (!flush)
                flags <= {w_n, w_z, w_v};
        end
    end

    // Branch condition evaluated on the registered flags only
    always_comb begin
        case (d_condition)
            3'b000:  br_taken = ~flags[1];
            3'b001:  br_taken = flags[1];
            3'b010:  br_taken = ~flags[1] & ~flags[2];
            3'b011:  br_taken = flags[2];
            3'b100:  br_taken = flags[1] | (~flags[1] & ~flags[2]);
            3'b101:  br_taken = flags[2] | flags[1];
            3'b110:  br_taken = flags[0];
            default: br_taken = 1'b1;
        endcase
    end

endmodule
`default_nettype wire
